// File: rtl/ascon_pkg.sv
// Shared types, round constants and the bitsliced round functions of the Ascon permutation.
package ascon_pkg;

    typedef struct packed {
        logic [63:0] x0;
        logic [63:0] x1;
        logic [63:0] x2;
        logic [63:0] x3;
        logic [63:0] x4;
    } ascon_state_t;

    localparam int ASCON_MAX_ROUNDS = 16;

    // Indexed by 16-rnd+i: a p12 job starts at entry 4 (0xf0).
    localparam logic [7:0] ASCON_ROUND_CONST [16] = '{
        8'h3c, 8'h2d, 8'h1e, 8'h0f, 8'hf0, 8'he1, 8'hd2, 8'hc3,
        8'hb4, 8'ha5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
    };

    typedef enum logic [1:0] {IDLE, RUN, DONE} perm_state_e;

    function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic ascon_state_t substitution_layer(input ascon_state_t s);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        ascon_state_t r;
        x0 = s.x0 ^ s.x4;
        x4 = s.x4 ^ s.x3;
        x2 = s.x2 ^ s.x1;
        x1 = s.x1;
        x3 = s.x3;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        r = '{x0: x0, x1: x1, x2: x2, x3: x3, x4: x4};
        return r;
    endfunction

    function automatic ascon_state_t linear_diffusion_layer(input ascon_state_t s);
        ascon_state_t r;
        r.x0 = s.x0 ^ ror64(s.x0, 19) ^ ror64(s.x0, 28);
        r.x1 = s.x1 ^ ror64(s.x1, 61) ^ ror64(s.x1, 39);
        r.x2 = s.x2 ^ ror64(s.x2, 1)  ^ ror64(s.x2, 6);
        r.x3 = s.x3 ^ ror64(s.x3, 10) ^ ror64(s.x3, 17);
        r.x4 = s.x4 ^ ror64(s.x4, 7)  ^ ror64(s.x4, 41);
        return r;
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, substitution layer, linear diffusion layer.
module ascon_round
    import ascon_pkg::*;
(
    input  ascon_state_t state,
    input  logic [7:0]   rc,
    output ascon_state_t next_state
);

    ascon_state_t added;

    // The constant touches only the low byte of x2.
    always_comb begin
        added          = state;
        added.x2[7:0]  = state.x2[7:0] ^ rc;
    end

    assign next_state = linear_diffusion_layer(substitution_layer(added));

endmodule

// File: rtl/ascon_permutation.sv
// Iterative Ascon-p[rnd] core: one round per clock, valid/ready job in, valid/ready result out.
module ascon_permutation
    import ascon_pkg::*;
#(
    parameter int MAX_ROUNDS = ASCON_MAX_ROUNDS
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         valid_i,
    output logic         ready_o,
    input  ascon_state_t state_i,
    input  logic [4:0]   rounds_i,
    output logic         valid_o,
    input  logic         ready_i,
    output ascon_state_t state_o,
    output logic         busy_o
);

    localparam logic [4:0] ROUND_LIMIT = 5'(MAX_ROUNDS);

    perm_state_e  fsm_reg, fsm_next;
    ascon_state_t state_reg;
    logic [3:0]   idx_reg;
    logic [4:0]   rnd_sat;
    logic [3:0]   start_idx;
    ascon_state_t round_in, round_out;
    logic [7:0]   round_rc;

    assign rnd_sat   = (rounds_i > ROUND_LIMIT) ? ROUND_LIMIT : rounds_i;
    // 16 - rnd modulo 16; only used when rnd is 1..16.
    assign start_idx = 4'd0 - rnd_sat[3:0];

    ascon_round u_round (
        .state      (round_in),
        .rc         (round_rc),
        .next_state (round_out)
    );

    // The first round is applied on the accept edge so latency equals the round count.
    always_comb begin
        fsm_next = fsm_reg;
        ready_o  = 1'b0;
        valid_o  = 1'b0;
        busy_o   = 1'b0;
        round_in = state_reg;
        round_rc = ASCON_ROUND_CONST[idx_reg];
        case (fsm_reg)
            IDLE: begin
                ready_o  = 1'b1;
                round_in = state_i;
                round_rc = ASCON_ROUND_CONST[start_idx];
                if (valid_i) begin
                    fsm_next = (rnd_sat <= 5'd1) ? DONE : RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                if (idx_reg == 4'd15) begin
                    fsm_next = DONE;
                end
            end
            DONE: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    fsm_next = IDLE;
                end
            end
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_reg   <= IDLE;
            state_reg <= '0;
            idx_reg   <= 4'd0;
        end else begin
            fsm_reg <= fsm_next;
            case (fsm_reg)
                IDLE: begin
                    if (valid_i) begin
                        state_reg <= (rnd_sat == 5'd0) ? state_i : round_out;
                        idx_reg   <= start_idx + 4'd1;
                    end
                end
                RUN: begin
                    state_reg <= round_out;
                    idx_reg   <= idx_reg + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign state_o = state_reg;

endmodule
